// File: rtl/puf_uart_pkg.sv
`default_nettype none
// ============================================================================
// puf_uart_pkg : shared types and defaults for the PUF UART frame front end.
// Macro UART_FRAME_CHECKSUM_EN adds the CHECK state. Rev 1.0
// ============================================================================
package puf_uart_pkg;

  localparam int         CLKS_PER_BIT         = 867;
  // Four 10-bit UART characters of silence.
  localparam int         TIMEOUT_CLKS_DEFAULT = 4 * 10 * CLKS_PER_BIT;
  localparam logic [7:0] SYNC_BYTE_DEFAULT    = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
`ifdef UART_FRAME_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    HOLD    = 2'd3
  } state_t;

endpackage : puf_uart_pkg
`default_nettype wire

// File: rtl/byte_gap_timer.sv
`default_nettype none
// ============================================================================
// byte_gap_timer : counts idle clocks between received bytes, flags expiry.
// Rev 1.0
// ============================================================================
module byte_gap_timer
  import puf_uart_pkg::*;
#(
  parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CNT_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LAST so expire stays asserted until the owner reacts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule : byte_gap_timer
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// uart_frame_parser : assembles SYNC-prefixed UART frames into a PUF challenge.
// Define UART_FRAME_CHECKSUM_EN to require a trailing XOR check byte. Rev 1.0
// ============================================================================
module uart_frame_parser
  import puf_uart_pkg::*;
#(
  parameter int         CHAL_BYTES   = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_DV_in,
  input  logic [7:0]              rx_Byte_in,
  input  logic                    chal_ready,
  output logic [8*CHAL_BYTES-1:0] chal_out,
  output logic                    chal_valid,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    busy
);

  localparam int               IDX_W    = (CHAL_BYTES > 1) ? $clog2(CHAL_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAL_BYTES - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [8*CHAL_BYTES-1:0] chal_q, chal_n;
  logic                    valid_q, valid_n;
  logic                    ferr_q, ferr_n;
  logic                    ovr_q, ovr_n;
  logic                    gap_en, gap_clr, gap_exp;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]              csum, csum_n;
`endif

  always_comb begin
    gap_en = (state == PAYLOAD);
`ifdef UART_FRAME_CHECKSUM_EN
    if (state == CHECK) gap_en = 1'b1;
`endif
  end

  // Outside the collecting states the counter is held at zero, which also
  // gives a clean start on entry to PAYLOAD.
  assign gap_clr = rx_DV_in || !gap_en;

  byte_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (gap_clr),
    .enable (gap_en),
    .expire (gap_exp)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    chal_n  = chal_q;
    valid_n = valid_q;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      HUNT: begin
        if (rx_DV_in && (rx_Byte_in == SYNC_BYTE)) begin
          state_n = PAYLOAD;
          idx_n   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_n  = '0;
`endif
        end
      end
      PAYLOAD: begin
        // Expiry wins over a coincident byte: that byte dies with the frame.
        if (gap_exp) begin
          ferr_n  = 1'b1;
          state_n = HUNT;
        end else if (rx_DV_in) begin
          chal_n[{idx, 3'b000} +: 8] = rx_Byte_in;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_n = csum ^ rx_Byte_in;
`endif
          if (idx == IDX_LAST) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_n = CHECK;
`else
            state_n = HOLD;
            valid_n = 1'b1;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      CHECK: begin
        if (gap_exp) begin
          ferr_n  = 1'b1;
          state_n = HUNT;
        end else if (rx_DV_in) begin
          if (rx_Byte_in == csum) begin
            state_n = HOLD;
            valid_n = 1'b1;
          end else begin
            ferr_n  = 1'b1;
            state_n = HUNT;
          end
        end
      end
`endif
      HOLD: begin
        ovr_n = rx_DV_in;
        if (chal_ready) begin
          valid_n = 1'b0;
          state_n = HUNT;
        end
      end
      default: begin
        state_n = HUNT;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      idx     <= '0;
      chal_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      chal_q  <= chal_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
      ovr_q   <= ovr_n;
`ifdef UART_FRAME_CHECKSUM_EN
      csum    <= csum_n;
`endif
    end
  end

  assign chal_out   = chal_q;
  assign chal_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state != HUNT);

endmodule : uart_frame_parser
`default_nettype wire

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter CHAL_BYTES, default 8: payload bytes per frame, legal range 1..16.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-003 Parameter TIMEOUT_CLKS, default 34680 (4 byte times at 867 clks/bit): maximum inter-byte gap in clk cycles.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port rx_DV_in, input, 1: one-cycle strobe, received byte valid, from UART receiver.
REQ-008 Port rx_Byte_in, input, 8: received byte, sampled only when rx_DV_in=1.
REQ-009 Port chal_ready, input, 1: downstream (PUF core) accepts challenge.
REQ-010 Port chal_out, output, 8*CHAL_BYTES: assembled challenge word.
REQ-011 Port chal_valid, output, 1: chal_out holds a complete, checked frame.
REQ-012 Port frame_err, output, 1: one-cycle pulse, frame discarded (timeout or checksum).
REQ-013 Port overrun, output, 1: one-cycle pulse, byte dropped while holding a challenge.
REQ-014 Port busy, output, 1: high in any state other than HUNT.

Function
REQ-015 States: HUNT, PAYLOAD, CHECK (only with checksum macro), HOLD.
REQ-016 HUNT: a byte equal to SYNC_BYTE -> PAYLOAD, byte index cleared; any other byte ignored, no error.
REQ-017 PAYLOAD: payload byte k (0-based) written to chal_out[8k+7:8k]; first byte occupies the LSBs.
REQ-018 PAYLOAD: a byte equal to SYNC_BYTE is data, not a restart.
REQ-019 After byte CHAL_BYTES-1: -> CHECK if checksum compiled in, else -> HOLD.
REQ-020 chal_valid rises on the clk edge that captures the final frame byte (payload or check); it is registered and asserts 1 cycle after that rx_DV_in.
REQ-021 HOLD: chal_valid=1 and chal_out stable until the cycle where chal_ready=1; then -> HUNT and chal_valid=0 on the next edge.
REQ-022 HOLD: any rx_DV_in, including one in the handshake cycle, drops the byte and pulses overrun for 1 cycle.
REQ-023 Gap counter: cleared on every rx_DV_in and on entry to PAYLOAD; counts only in PAYLOAD/CHECK.
REQ-024 Timeout: gap counter reaches TIMEOUT_CLKS-1 with no byte -> frame_err pulse, -> HUNT, partial frame discarded, chal_valid stays 0.
REQ-025 A byte arriving in the timeout cycle is discarded with the frame and is not reinterpreted as a sync byte.
REQ-026 chal_out is updated only in PAYLOAD; it may hold stale or partial data whenever chal_valid=0.
REQ-027 frame_err and overrun never assert in the same cycle as a rising chal_valid.

Reset
REQ-028 On rst: state HUNT; chal_valid, frame_err, overrun and busy =0; chal_out all-zero; byte index, gap counter and checksum accumulator =0.
REQ-029 rst mid-frame or in HOLD aborts immediately; no pulse is generated on release.
REQ-030 First rx_DV_in evaluated on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro UART_FRAME_CHECKSUM_EN defined: frame = SYNC, CHAL_BYTES payload bytes, one check byte equal to the XOR of all payload bytes.
REQ-032 Check byte match -> HOLD; mismatch -> frame_err pulse, -> HUNT, chal_valid stays 0.
REQ-033 Macro undefined: no CHECK state and no accumulator; frame = SYNC plus payload only.

Structure
REQ-034 Shared package puf_uart_pkg holds the state enum, SYNC_BYTE default, TIMEOUT_CLKS default and CLKS_PER_BIT=867.
REQ-035 Sub-module byte_gap_timer (clear, enable, expire pulse, parameter TIMEOUT_CLKS) implements REQ-023/024; the parser FSM stays in the top module.

Verification
REQ-036 Bytes A5, 01..08 (macro off), chal_ready=1 -> chal_valid for 1 cycle, chal_out=64'h0807060504030201.
REQ-037 Macro on: A5, 01..08, check byte 08 -> valid; repeat with check byte 09 -> frame_err pulse, no valid.
REQ-038 A5 followed by 3 bytes, then idle 34680 clks -> frame_err exactly once, busy=0, next A5 frame succeeds.
REQ-039 Frame complete with chal_ready=0, inject byte 5A -> overrun pulse, chal_out unchanged; raise ready -> valid drops next cycle.
REQ-040 Bytes 00, FF, A5, A5x8 (macro off) -> leading bytes ignored; chal_out=64'hA5A5A5A5A5A5A5A5.
REQ-041 Assert rst after 4 payload bytes -> all outputs 0 at once; clean frame after release passes.
